// File: rtl/alignment_result_reader.sv
// alignment_result_reader: polls a solver status word over Avalon-MM and streams its traceback directions.
// Optional POLL_TIMEOUT_EN macro adds a MAX_POLLS poll limit and an ERR state.
module alignment_result_reader #(
  parameter int ADDR_W      = 6,
  parameter int STATUS_ADDR = 0,
  parameter int NUM_DIRS    = 19,
  parameter int POLL_GAP    = 4,
  parameter int MAX_POLLS   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [7:0]        avm_byteenable,
  input  logic [63:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  output logic              dir_valid,
  input  logic              dir_ready,
  output logic [1:0]        dir_data,
  output logic [4:0]        dir_index,
  output logic              dir_last
);
  localparam int SW = 2 * NUM_DIRS;
  localparam int GW = $clog2(POLL_GAP + 2);
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, GAP, EMIT, DONE
`ifdef POLL_TIMEOUT_EN
    , ERR
`endif
  } state_t;
  state_t        state, state_n;
  logic [SW-1:0] sh, sh_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [4:0]    idx_n;
  logic          unused;
  assign unused         = ^avm_readdata;
  assign avm_address    = ADDR_W'(STATUS_ADDR);
  assign avm_byteenable = 8'hFF;
`ifdef POLL_TIMEOUT_EN
  localparam int PW = $clog2(MAX_POLLS + 1);
  logic [PW-1:0] polls, polls_n;
`endif
  always_comb begin
    state_n = state;
    sh_n    = sh;
    gap_n   = gap_cnt;
    idx_n   = dir_index;
`ifdef POLL_TIMEOUT_EN
    polls_n = polls;
`endif
    case (state)
      REQ: if (!avm_waitrequest) begin
        state_n = WAIT;
`ifdef POLL_TIMEOUT_EN
        polls_n = polls + 1'b1;
`endif
      end
      WAIT: if (avm_readdatavalid) begin
        if (avm_readdata[0]) begin
          state_n = EMIT;
          sh_n    = avm_readdata[SW+1:2];
          idx_n   = '0;
        end else begin
          gap_n   = '0;
          state_n = POLL_GAP == 0 ? REQ : GAP;
`ifdef POLL_TIMEOUT_EN
          if (polls == PW'(MAX_POLLS)) state_n = ERR;
`endif
        end
      end
      GAP: begin
        state_n = gap_cnt == GW'(POLL_GAP - 1) ? REQ : GAP;
        gap_n   = gap_cnt + 1'b1;
      end
      EMIT: if (dir_ready) begin
        sh_n    = sh >> 2;
        idx_n   = dir_index + 1'b1;
        state_n = dir_last ? DONE : EMIT;
      end
      default: begin
        state_n = start ? REQ : state;
`ifdef POLL_TIMEOUT_EN
        polls_n = '0;
`endif
      end
    endcase
  end
  // Outputs are registered from the next state so they line up with the state flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sh        <= '0;
      gap_cnt   <= '0;
      avm_read  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dir_valid <= 1'b0;
      dir_data  <= '0;
      dir_index <= '0;
      dir_last  <= 1'b0;
    end else begin
      state     <= state_n;
      sh        <= sh_n;
      gap_cnt   <= gap_n;
      avm_read  <= state_n == REQ;
      busy      <= state_n inside {REQ, WAIT, GAP, EMIT};
      done      <= state_n == DONE;
      dir_valid <= state_n == EMIT;
      dir_data  <= sh_n[1:0];
      dir_index <= idx_n;
      dir_last  <= state_n == EMIT && idx_n == 5'(NUM_DIRS - 1);
    end
  end
`ifdef POLL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      polls <= '0;
      error <= 1'b0;
    end else begin
      polls <= polls_n;
      error <= state_n == ERR;
    end
  end
`else
  assign error = 1'b0;
`endif
endmodule
